// File: rtl/coa_ctrl_pkg.sv
// Shared controller definitions: control-word bit positions, REGDST encodings and
// instruction field ranges used by the register-file stage.
package coa_ctrl_pkg;

  localparam int CTRL_W    = 22;
  localparam int DEF_DW    = 32;
  localparam int DEF_NREG  = 32;

  localparam int REGWRITE  = 13;
  localparam int REGDST_HI = 12;
  localparam int REGDST_LO = 11;
  localparam int REGINSRC  = 10;
  localparam int DREGSEL1  = 9;
  localparam int DREGSEL0  = 8;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int RI_HI = 10;
  localparam int RI_LO = 6;

  localparam int LINK_REG = 31;

  typedef enum logic [1:0] {
    RD_RT  = 2'b00,
    RD_RD  = 2'b01,
    RD_R31 = 2'b10,
    RD_RI  = 2'b11
  } regdst_e;

endpackage

// File: rtl/reg_file_stage_if.sv
// Bus between the controller/datapath and the register-file stage.
// With REGFILE_DBG_PORT_EN defined the bus also carries the debug read port.
interface reg_file_stage_if #(
  parameter int DW = 32
);
  logic [21:0]   ctrl_in;
  logic [31:0]   instr;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] x_q;
  logic [DW-1:0] y_q;
  logic [DW-1:0] data_q;
  logic [4:0]    wb_addr;

`ifdef REGFILE_DBG_PORT_EN
  logic [4:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  modport master (
    output ctrl_in, instr, alu_res, mem_rdata, dbg_addr,
    input  x_q, y_q, data_q, wb_addr, dbg_data
  );
  modport slave (
    input  ctrl_in, instr, alu_res, mem_rdata, dbg_addr,
    output x_q, y_q, data_q, wb_addr, dbg_data
  );
`else
  modport master (
    output ctrl_in, instr, alu_res, mem_rdata,
    input  x_q, y_q, data_q, wb_addr
  );
  modport slave (
    input  ctrl_in, instr, alu_res, mem_rdata,
    output x_q, y_q, data_q, wb_addr
  );
`endif

endinterface

// File: rtl/reg_array.sv
// NREG x DW register array: two async read ports, one sync write port, r0 hardwired
// to zero, async clear. REGFILE_DBG_PORT_EN adds a third async read port.
module reg_array #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] raddrA,
  output logic [DW-1:0] rdataA,
  input  logic [AW-1:0] raddrB,
  output logic [DW-1:0] rdataB,
`ifdef REGFILE_DBG_PORT_EN
  input  logic [AW-1:0] raddrC,
  output logic [DW-1:0] rdataC,
`endif
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs [NREG];

  // Entry 0 is only ever cleared; reads of address 0 are forced to zero below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdataA = (raddrA == '0) ? '0 : regs[raddrA];
  assign rdataB = (raddrB == '0) ? '0 : regs[raddrB];
`ifdef REGFILE_DBG_PORT_EN
  assign rdataC = (raddrC == '0) ? '0 : regs[raddrC];
`endif

endmodule

// File: rtl/reg_file_stage.sv
// Register-file stage: operand/write-back address muxing, write-first bypass and the
// x/y/data latches. REGFILE_DBG_PORT_EN exposes a bypass-free debug read of the array.
module reg_file_stage
  import coa_ctrl_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG
) (
  input logic             clk,
  input logic             reset,
  reg_file_stage_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [AW-1:0] rs, rt, rd, ri;
  logic [AW-1:0] xAddr, yAddr, wbAddr;
  logic [DW-1:0] wbData, xRead, yRead, xNext, yNext;
  logic [DW-1:0] xQ, yQ, dataQ;
  logic          wbEn;
  regdst_e       regDst;
  logic          unusedBits;

  assign rs = bus.instr[RS_HI:RS_LO];
  assign rt = bus.instr[RT_HI:RT_LO];
  assign rd = bus.instr[RD_HI:RD_LO];
  assign ri = bus.instr[RI_HI:RI_LO];

  assign unusedBits = ^{bus.ctrl_in[21:14], bus.ctrl_in[7:0], bus.instr[31:26], bus.instr[5:0]};

  assign xAddr  = bus.ctrl_in[DREGSEL0] ? rd : rs;
  assign yAddr  = bus.ctrl_in[DREGSEL1] ? ri : rt;
  assign regDst = regdst_e'(bus.ctrl_in[REGDST_HI:REGDST_LO]);

  always_comb begin
    wbAddr = rt;
    case (regDst)
      RD_RT:   wbAddr = rt;
      RD_RD:   wbAddr = rd;
      RD_R31:  wbAddr = AW'(LINK_REG);
      RD_RI:   wbAddr = ri;
      default: wbAddr = rt;
    endcase
  end

  // Write-back from the memory data register reads the value latched on the previous edge.
  assign wbData = bus.ctrl_in[REGINSRC] ? bus.alu_res : dataQ;
  assign wbEn   = bus.ctrl_in[REGWRITE] && (wbAddr != '0);

  reg_array #(.DW(DW), .NREG(NREG), .AW(AW)) u_array (
    .clk    (clk),
    .reset  (reset),
    .raddrA (xAddr),
    .rdataA (xRead),
    .raddrB (yAddr),
    .rdataB (yRead),
`ifdef REGFILE_DBG_PORT_EN
    .raddrC (bus.dbg_addr),
    .rdataC (bus.dbg_data),
`endif
    .we     (wbEn),
    .waddr  (wbAddr),
    .wdata  (wbData)
  );

  // wbEn already excludes r0, so a matching address here is always nonzero.
  assign xNext = (wbEn && (wbAddr == xAddr)) ? wbData : xRead;
  assign yNext = (wbEn && (wbAddr == yAddr)) ? wbData : yRead;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xQ    <= '0;
      yQ    <= '0;
      dataQ <= '0;
    end else begin
      xQ    <= xNext;
      yQ    <= yNext;
      dataQ <= bus.mem_rdata;
    end
  end

  assign bus.x_q     = xQ;
  assign bus.y_q     = yQ;
  assign bus.data_q  = dataQ;
  assign bus.wb_addr = 5'(wbAddr);

endmodule

// File: tb/tb_reg_file_stage.sv
// Directed bench for reg_file_stage: a register-array model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_reg_file_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_on = 1'b0;

  always #5 clk = ~clk;

  reg_file_stage_if #(.DW(32)) bus ();

  reg_file_stage #(.DW(32), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] mkc(bit wr, logic [1:0] dst, bit insrc, bit s1, bit s0);
    logic [21:0] c;
    c        = '0;
    c[21:14] = 8'hA5;  // ignored bits, set to prove they are ignored
    c[7:0]   = 8'h3C;
    c[13]    = wr;
    c[12:11] = dst;
    c[10]    = insrc;
    c[9]     = s1;
    c[8]     = s0;
    return c;
  endfunction

  function automatic logic [31:0] mki(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] ri);
    return {6'h23, rs, rt, rd, ri, 6'h15};
  endfunction

  // Register-array model: architectural GPRs and the values the latches must hold.
  logic [31:0] m_regs [32];
  logic [31:0] exp_x, exp_y, exp_data;

  function automatic logic [4:0] exp_wb(logic [21:0] c, logic [31:0] i);
    case (c[12:11])
      2'b00:   return i[20:16];
      2'b01:   return i[15:11];
      2'b10:   return 5'd31;
      default: return i[10:6];
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      exp_x = '0; exp_y = '0; exp_data = '0;
    end else begin
      logic [4:0]  wa, xa, ya;
      logic [31:0] wd;
      bit          wr;
      wa = exp_wb(bus.ctrl_in, bus.instr);
      wd = bus.ctrl_in[10] ? bus.alu_res : exp_data;
      wr = bus.ctrl_in[13] && (wa != 0);
      xa = bus.ctrl_in[8] ? bus.instr[15:11] : bus.instr[25:21];
      ya = bus.ctrl_in[9] ? bus.instr[10:6]  : bus.instr[20:16];
      exp_x = (xa == 0) ? 32'd0 : ((wr && xa == wa) ? wd : m_regs[xa]);
      exp_y = (ya == 0) ? 32'd0 : ((wr && ya == wa) ? wd : m_regs[ya]);
      if (wr) m_regs[wa] = wd;
      exp_data = bus.mem_rdata;
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_on && !reset) begin
      check("model_x_q", bus.x_q, exp_x);
      check("model_y_q", bus.y_q, exp_y);
      check("model_data_q", bus.data_q, exp_data);
      check("model_wb_addr", 32'(bus.wb_addr), 32'(exp_wb(bus.ctrl_in, bus.instr)));
    end
  end

  task automatic drive(input logic [21:0] c, input logic [31:0] i, input logic [31:0] a, input logic [31:0] m);
    bus.ctrl_in   = c;
    bus.instr     = i;
    bus.alu_res   = a;
    bus.mem_rdata = m;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.ctrl_in   = '0;
    bus.instr     = '0;
    bus.alu_res   = '0;
    bus.mem_rdata = '0;
`ifdef REGFILE_DBG_PORT_EN
    bus.dbg_addr  = '0;
`endif
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    model_on = 1'b1;

    // 1: reset pulsed before the edge of an in-flight write to r5
    bus.ctrl_in   = mkc(1, 2'b01, 1, 0, 0);
    bus.instr     = mki(5'd0, 5'd0, 5'd5, 5'd0);
    bus.alu_res   = 32'hDEADBEEF;
    bus.mem_rdata = 32'h1111_2222;
    #1 reset = 1'b1;
    @(posedge clk);
    #2;
    check("rst_x_q", bus.x_q, 32'h0);
    check("rst_y_q", bus.y_q, 32'h0);
    check("rst_data_q", bus.data_q, 32'h0);
    reset = 1'b0;
    drive(mkc(0, 2'b00, 0, 0, 1), mki(5'd0, 5'd0, 5'd5, 5'd0), 32'h0, 32'h0);
    check("rst_r5_dropped", bus.x_q, 32'h0);

    // 2: R-type write-back to rd=7, then read through rs
    drive(mkc(1, 2'b01, 1, 0, 0), mki(5'd0, 5'd0, 5'd7, 5'd0), 32'h12345678, 32'h0);
    drive(mkc(0, 2'b00, 0, 0, 0), mki(5'd7, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0);
    check("rtype_x_q", bus.x_q, 32'h12345678);
`ifdef REGFILE_DBG_PORT_EN
    bus.dbg_addr = 5'd7;
    #1 check("dbg_r7", bus.dbg_data, 32'h12345678);
    bus.dbg_addr = 5'd0;
    #1 check("dbg_r0", bus.dbg_data, 32'h0);
`endif

    // 3: write to r0 is dropped; same-cycle write/read of r0 reads 0
    bus.ctrl_in = mkc(1, 2'b00, 1, 0, 0);
    bus.instr   = mki(5'd0, 5'd0, 5'd0, 5'd0);
    #1 check("r0_wb_addr", 32'(bus.wb_addr), 32'h0);
    drive(mkc(1, 2'b00, 1, 0, 0), mki(5'd0, 5'd0, 5'd0, 5'd0), 32'hFFFFFFFF, 32'h0);
    check("r0_same_cycle_x", bus.x_q, 32'h0);
    check("r0_same_cycle_y", bus.y_q, 32'h0);
    drive(mkc(0, 2'b00, 0, 0, 0), mki(5'd0, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0);
    check("r0_read_x", bus.x_q, 32'h0);

    // 4: write-first bypass on both read ports
    drive(mkc(1, 2'b01, 1, 0, 0), mki(5'd3, 5'd3, 5'd3, 5'd0), 32'hA5A5A5A5, 32'h0);
    check("bypass_x", bus.x_q, 32'hA5A5A5A5);
    check("bypass_y", bus.y_q, 32'hA5A5A5A5);

    // 5: LW path, S3 then S4 writes the latched data register to rt=9
    drive(mkc(0, 2'b00, 0, 0, 0), mki(5'd0, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0000CAFE);
    check("lw_s3_data_q", bus.data_q, 32'h0000CAFE);
    drive(mkc(1, 2'b00, 0, 0, 0), mki(5'd0, 5'd9, 5'd0, 5'd0), 32'h0, 32'h00001234);
    check("lw_s4_data_q", bus.data_q, 32'h00001234);
    drive(mkc(0, 2'b00, 0, 0, 0), mki(5'd9, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0);
    check("lw_r9", bus.x_q, 32'h0000CAFE);

    // 6: DXOR sequence and JAL
    drive(mkc(1, 2'b01, 1, 0, 0), mki(5'd0, 5'd0, 5'd4, 5'd0), 32'h000000F0, 32'h0);
    drive(mkc(1, 2'b01, 1, 0, 0), mki(5'd0, 5'd0, 5'd2, 5'd0), 32'h0000000F, 32'h0);
    drive(mkc(0, 2'b00, 0, 1, 1), mki(5'd0, 5'd6, 5'd4, 5'd2), 32'h0, 32'h0);
    check("dxor_s10_x", bus.x_q, 32'h000000F0);
    check("dxor_s10_y", bus.y_q, 32'h0000000F);
    drive(mkc(1, 2'b00, 1, 1, 1), mki(5'd0, 5'd6, 5'd4, 5'd2), 32'h000000FF, 32'h0);
    check("dxor_s11_ri_old", bus.y_q, 32'h0000000F);
    bus.ctrl_in = mkc(1, 2'b11, 1, 1, 1);
    #1 check("dxor_s12_wb_addr", 32'(bus.wb_addr), 32'd2);
    drive(mkc(1, 2'b11, 1, 1, 1), mki(5'd0, 5'd6, 5'd4, 5'd2), 32'h000000FF, 32'h0);
    check("dxor_s12_bypass_y", bus.y_q, 32'h000000FF);
    drive(mkc(0, 2'b00, 0, 1, 0), mki(5'd6, 5'd0, 5'd0, 5'd2), 32'h0, 32'h0);
    check("dxor_r6", bus.x_q, 32'h000000FF);
    check("dxor_r2", bus.y_q, 32'h000000FF);
    bus.ctrl_in = mkc(1, 2'b10, 1, 0, 0);
    #1 check("jal_wb_addr", 32'(bus.wb_addr), 32'd31);
    drive(mkc(1, 2'b10, 1, 0, 0), mki(5'd0, 5'd0, 5'd0, 5'd0), 32'h00000104, 32'h0);
    drive(mkc(0, 2'b00, 0, 0, 1), mki(5'd0, 5'd0, 5'd31, 5'd0), 32'h0, 32'h0);
    check("jal_r31", bus.x_q, 32'h00000104);

    repeat (2) drive(mkc(0, 2'b00, 0, 0, 0), mki(5'd0, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
